timer_irq_ctrl: RTL
===================

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter: TMS_W, 13, width of the millisecond period bus.
REQ-002 Parameter: RESTART_GAP, 2, number of cycles Tms is held at 0 before each new period (range 1..15).
REQ-003 Port: clk  input  1  system clock (50 MHz).
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: wr_en  input  1  CPU write strobe, one cycle.
REQ-006 Port: wr_data  input  TMS_W  requested period in ms; 0 means stop.
REQ-007 Port: wr_auto  input  1  auto-reload select, sampled with wr_en.
REQ-008 Port: ack  input  1  CPU interrupt acknowledge, one cycle.
REQ-009 Port: rdy  input  1  expiry flag from CPUTimer; high while expired, cleared when Tms=0.
REQ-010 Port: Tms  output  TMS_W  period driven to CPUTimer.
REQ-011 Port: irq  output  1  sticky interrupt request.
REQ-012 Port: busy  output  1  high in GAP and RUN.
REQ-013 Port: overrun  output  1  sticky missed-acknowledge flag (TIMER_OVERRUN_EN only).

Function
REQ-014 The block SHALL implement the FSM states IDLE, GAP and RUN, with all outputs registered.
REQ-015 IDLE SHALL drive Tms=0 and busy=0, and SHALL ignore rdy.
REQ-016 A wr_en with nonzero wr_data sampled at edge k SHALL latch period and auto, enter GAP at k+1 with Tms=0 for RESTART_GAP cycles, then enter RUN with Tms=period.
REQ-017 A wr_en with wr_data=0 SHALL enter IDLE at the next edge from any state, leaving irq unchanged.
REQ-018 A nonzero wr_en in GAP or RUN SHALL restart via GAP with the new period; the expiry in progress is discarded.
REQ-019 In RUN, rdy=1 sampled at edge m SHALL set irq=1 at m+1.
REQ-020 On that expiry, single-shot mode SHALL enter IDLE at m+1 and auto mode SHALL enter GAP at m+1; in both modes Tms=0 at m+1.
REQ-021 ack sampled with irq=1 SHALL clear irq at the next edge; ack with irq=0 SHALL have no effect.
REQ-022 If ack and an expiry occur in the same cycle, irq SHALL remain 1 (expiry wins).
REQ-023 If wr_en and an expiry occur in the same cycle, wr_en SHALL win and no irq SHALL be raised.
REQ-024 The GAP counter SHALL be ceil(log2(RESTART_GAP+1)) bits wide and SHALL not wrap.

Reset
REQ-025 While rst=0 the block SHALL asynchronously force state=IDLE, Tms=0, irq=0, busy=0, overrun=0, period=0 and auto=0.
REQ-026 Reset asserted mid-RUN SHALL abandon the period with no irq raised; the first edge after release SHALL behave as IDLE.

Configuration
REQ-027 With TIMER_OVERRUN_EN defined, an expiry while irq=1 SHALL set overrun=1 at the next edge, and ack SHALL clear overrun together with irq.
REQ-028 Without TIMER_OVERRUN_EN, the overrun port SHALL be tied to 0 and SHALL contain no overrun logic.

Structure
REQ-029 The package timer_pkg SHALL hold the state enum (IDLE/GAP/RUN), TMS_W_DEFAULT and the clock-cycles-per-ms constant 50000.
REQ-030 The block SHALL have no sub-module; CPUTimer is instantiated beside it at the parent level.

Verification
REQ-031 The bench SHALL check reset: rst=0 mid-operation -> Tms=0, irq=0, busy=0, state=IDLE within the same cycle.
REQ-032 The bench SHALL check single-shot: write 5 ms, auto=0 -> Tms=0 for 2 cycles then Tms=5; rdy after 250000 cycles -> irq=1 next cycle, Tms=0, busy=0; ack -> irq=0.
REQ-033 The bench SHALL check auto-reload: write 2 ms, auto=1 -> three expiries at 100000-cycle spacing plus GAP; irq stays 1 with no ack; overrun=1 after the 2nd expiry (macro on) or remains 0 (macro off).
REQ-034 The bench SHALL check stop: write 0 while in RUN -> IDLE and Tms=0 next cycle; pending irq retained.
REQ-035 The bench SHALL check simultaneous events: ack on the expiry cycle -> irq remains 1; wr_en(7) on the expiry cycle -> no irq, GAP entered, then Tms=7.
REQ-036 The bench SHALL check restart: write 10 then write 3 mid-RUN -> GAP for 2 cycles, Tms=3, single irq after 150000 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the CPU timer interrupt controller.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2
    } timer_state_e;

    localparam int unsigned TMS_W_DEFAULT = 13;
    localparam int unsigned CYCLES_PER_MS = 50000;

endpackage

// File: rtl/timer_irq_ctrl.sv
// Sequences millisecond periods into CPUTimer and turns its expiry flag into a sticky irq.
// Optional missed-acknowledge tracking is built only when TIMER_OVERRUN_EN is defined.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TMS_W       = TMS_W_DEFAULT,
    parameter int unsigned RESTART_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TMS_W-1:0] wr_data,
    input  logic             wr_auto,
    input  logic             ack,
    input  logic             rdy,
    output logic [TMS_W-1:0] Tms,
    output logic             irq,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned          GAP_W    = $clog2(RESTART_GAP + 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(RESTART_GAP - 1);

    timer_state_e     r_state;
    logic [TMS_W-1:0] r_period;
    logic             r_auto;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TMS_W-1:0] r_tms;
    logic             r_irq;
    logic             r_busy;
    logic             w_expire;

    // A CPU write in the same cycle as an expiry discards that expiry.
    assign w_expire = (r_state == RUN) && rdy && !wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_period  <= '0;
            r_auto    <= 1'b0;
            r_gap_cnt <= '0;
            r_tms     <= '0;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (wr_en) begin
                r_tms <= '0;
                if (wr_data != '0) begin
                    r_period  <= wr_data;
                    r_auto    <= wr_auto;
                    r_state   <= GAP;
                    r_gap_cnt <= '0;
                    r_busy    <= 1'b1;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_tms  <= '0;
                        r_busy <= 1'b0;
                    end
                    GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state <= RUN;
                            r_tms   <= r_period;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (rdy) begin
                            r_state   <= r_auto ? GAP : IDLE;
                            r_busy    <= r_auto;
                            r_gap_cnt <= '0;
                            r_tms     <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tms   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            if (w_expire)
                r_irq <= 1'b1;
            else if (ack)
                r_irq <= 1'b0;
        end
    end

`ifdef TIMER_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_overrun <= 1'b0;
        else if (w_expire && r_irq)
            r_overrun <= 1'b1;
        else if (ack && r_irq)
            r_overrun <= 1'b0;
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    assign Tms  = r_tms;
    assign irq  = r_irq;
    assign busy = r_busy;

endmodule
